// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for pipeline stage buffers: control-state encodings and default bundle widths.
// The state encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
package pipe_stage_buf_pkg;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b11;

    localparam int EXMEM_W = 213;
    localparam int IDEX_W  = 148;
    localparam int MEMWB_W = 104;

    // Number of entries held for a given {s_v, m_v} state.
    function automatic logic [1:0] st_count(input logic [1:0] st);
        return {1'b0, st[1]} + {1'b0, st[0]};
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready payload channel between pipeline stages.
// The master drives valid/data and samples ready; the slave does the reverse.
interface pipe_stage_buf_if
    import pipe_stage_buf_pkg::*;
#(
    parameter int WIDTH = EXMEM_W
);

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_stage_buf_data_reg.sv
// Payload register with async reset, load enable and optional synchronous clear; 1-cycle latency.
// No handshake of its own: load/clear come from the owning stage's control logic.
module pipe_stage_buf_data_reg #(
    parameter int WIDTH      = 8,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // With CLEAR_DATA=0 the clear request is ignored so the payload just holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear && CLEAR_DATA) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with 2-entry skid buffer, flush and bubble counter; 1-cycle latency.
// in_ready is registered (deasserts only when the skid entry is full); full throughput while out_ready=1.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int WIDTH      = EXMEM_W,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_buf_if.slave  up,
    pipe_stage_buf_if.master dn,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             m_v;
    logic             s_v;
    logic             in_fire;
    logic             out_fire;
    logic             m_load;
    logic             m_from_skid;
    logic             m_clr;
    logic             s_load;
    logic             s_clr;
    logic [WIDTH-1:0] m_d;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] m_nxt;

    assign m_v      = state_q[0];
    assign s_v      = state_q[1];
    assign in_fire  = up.valid & ~s_v;
    assign out_fire = m_v & dn.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_fire) state_d = ST_ONE;
            ST_ONE: begin
                if (in_fire && !out_fire) begin
                    state_d = ST_TWO;
                end else if (!in_fire && out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO:   if (out_fire) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
        // Squash wins over everything, including a concurrent accept.
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        m_load      = 1'b0;
        m_from_skid = 1'b0;
        m_clr       = 1'b0;
        s_load      = 1'b0;
        s_clr       = 1'b0;
        if (flush) begin
            m_clr = 1'b1;
            s_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: m_load = in_fire;
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        m_load = 1'b1;
                    end else if (in_fire) begin
                        s_load = 1'b1;
                    end else if (out_fire) begin
                        m_clr = 1'b1;
                    end
                end
                ST_TWO: begin
                    m_load      = out_fire;
                    m_from_skid = out_fire;
                end
                default: begin
                    m_clr = 1'b1;
                    s_clr = 1'b1;
                end
            endcase
        end
    end

    assign m_nxt = m_from_skid ? s_d : up.data;

    pipe_stage_buf_data_reg #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (m_load),
        .clear (m_clr),
        .d     (m_nxt),
        .q     (m_d)
    );

    pipe_stage_buf_data_reg #(
        .WIDTH      (WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (s_load),
        .clear (s_clr),
        .d     (up.data),
        .q     (s_d)
    );

    assign up.ready  = ~s_v;
    assign dn.valid  = m_v;
    assign dn.data   = m_d;
    assign occupancy = st_count(state_q);

    // Saturating idle-downstream counter; flush deliberately leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (dn.ready && !m_v && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule
